// File: rtl/wshbn_slave_ram_pkg.sv
// ============================================================================
// Module      : wshbn_slave_ram_pkg
// Description : Shared widths, main-memory map constants and the responder
//               FSM state type for the Wishbone RAM responder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package wshbn_slave_ram_pkg;

    // Bus widths shared with the cache refill/writeback master
    localparam int unsigned ADDR_WIDTH = 32;
    localparam int unsigned WORD_WIDTH = 32;

    // Main-memory region of the memory map (word addresses)
    localparam logic [ADDR_WIDTH-1:0] RAM_BASE_ADDR = 32'h0000_4000;
    localparam int unsigned           RAM_DEPTH     = 256;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } wshbn_slave_st_t;

    // Index width for an array of the given depth (never below one bit)
    function automatic int unsigned idx_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/wshbn_slave_ram_if.sv
// ============================================================================
// Module      : wshbn_slave_ram_if
// Description : Wishbone classic single-beat bus between the cache master and
//               the RAM responder. ERR_O exists only when
//               WSHBN_SLAVE_RAM_ERR_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface wshbn_slave_ram_if;

    logic [wshbn_slave_ram_pkg::ADDR_WIDTH-1:0] ADR_I;
    logic [wshbn_slave_ram_pkg::WORD_WIDTH-1:0] DAT_I;
    logic                                       WE_I;
    logic                                       STB_I;
    logic                                       CYC_I;
    logic [wshbn_slave_ram_pkg::WORD_WIDTH-1:0] DAT_O;
    logic                                       ACK_O;
`ifdef WSHBN_SLAVE_RAM_ERR_EN
    logic                                       ERR_O;

    modport master (output ADR_I, DAT_I, WE_I, STB_I, CYC_I,
                    input  DAT_O, ACK_O, ERR_O);
    modport slave  (input  ADR_I, DAT_I, WE_I, STB_I, CYC_I,
                    output DAT_O, ACK_O, ERR_O);
`else
    modport master (output ADR_I, DAT_I, WE_I, STB_I, CYC_I,
                    input  DAT_O, ACK_O);
    modport slave  (input  ADR_I, DAT_I, WE_I, STB_I, CYC_I,
                    output DAT_O, ACK_O);
`endif

endinterface

`default_nettype wire

// File: rtl/wshbn_slave_ram_array.sv
// ============================================================================
// Module      : wshbn_slave_ram_array
// Description : Synchronous single-port storage with registered read data,
//               kept apart from the handshake FSM so it maps onto block RAM.
//               Storage itself is never reset; only the read register is.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wshbn_slave_ram_array #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned IDX_W = 8,
    parameter int unsigned DATA_W = 32
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              we,
    input  wire logic              re,
    input  wire logic [IDX_W-1:0]  addr,
    input  wire logic [DATA_W-1:0] wdata,
    output logic      [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Write port: contents survive reset
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[addr] <= wdata;
        end
    end

    // Registered read port, cleared by reset so the bus reads 0 afterwards
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= r_mem[addr];
        end
    end

endmodule

`default_nettype wire

// File: rtl/wshbn_slave_ram.sv
// ============================================================================
// Module      : wshbn_slave_ram
// Description : Wishbone classic RAM responder for the main-memory region.
//               Each single-beat read/write is acknowledged WAIT_STATES+1
//               cycles after the request is first seen in IDLE.
//               Optional macro WSHBN_SLAVE_RAM_ERR_EN: out-of-range beats
//               answer with ERR_O instead of ACK_O.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wshbn_slave_ram
    import wshbn_slave_ram_pkg::*;
#(
    parameter int unsigned            MEM_DEPTH   = RAM_DEPTH,
    parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR   = RAM_BASE_ADDR,
    parameter int unsigned            WAIT_STATES = 2
) (
    input  wire logic         CLK_I,
    input  wire logic         RST_I,
    wshbn_slave_ram_if.slave  bus
);

    localparam int unsigned          c_idx_w    = idx_width(MEM_DEPTH);
    localparam logic [ADDR_WIDTH:0]  c_end_addr = {1'b0, BASE_ADDR} + (ADDR_WIDTH+1)'(MEM_DEPTH);
    localparam logic [3:0]           c_ws       = 4'(WAIT_STATES);

    wshbn_slave_st_t      r_state;
    wshbn_slave_st_t      w_state_nxt;
    logic [3:0]           r_wait_cnt;
    logic [3:0]           w_wait_cnt_nxt;
    logic                 r_rd_miss;

    logic                 w_req;
    logic                 w_hit;
    logic                 w_resp;
    logic                 w_rd_en;
    logic                 w_wr_en;
    logic [c_idx_w-1:0]   w_index;
    logic [WORD_WIDTH-1:0] w_rdata;

    assign w_req   = bus.CYC_I & bus.STB_I;
    // Compare one bit wider so BASE_ADDR+MEM_DEPTH cannot wrap
    assign w_hit   = ({1'b0, bus.ADR_I} >= {1'b0, BASE_ADDR}) && ({1'b0, bus.ADR_I} < c_end_addr);
    assign w_index = c_idx_w'(bus.ADR_I - BASE_ADDR);
    assign w_resp  = (r_state == RESP);
    // Read data is captured on the edge entering RESP
    assign w_rd_en = (w_state_nxt == RESP);
    // Write commits on the edge leaving RESP, only if the master still requests
    assign w_wr_en = w_resp & w_hit & bus.WE_I & w_req;

    // FSM state and wait-state counter
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            r_state    <= IDLE;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
        end
    end

    // Next-state logic: IDLE -> (WAIT)* -> RESP -> IDLE, abort from WAIT
    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    if (c_ws == 4'd0) begin
                        w_state_nxt = RESP;
                    end else begin
                        w_state_nxt    = WAIT;
                        w_wait_cnt_nxt = 4'd1;
                    end
                end
            end
            WAIT: begin
                if (!w_req) begin
                    w_state_nxt = IDLE;
                end else if (r_wait_cnt == c_ws) begin
                    w_state_nxt = RESP;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + 4'd1;
                end
            end
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Remember whether the captured read was a miss so DAT_O reads as 0
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            r_rd_miss <= 1'b0;
        end else if (w_rd_en) begin
            r_rd_miss <= ~w_hit;
        end
    end

    wshbn_slave_ram_array #(
        .DEPTH  (MEM_DEPTH),
        .IDX_W  (c_idx_w),
        .DATA_W (WORD_WIDTH)
    ) u_array (
        .clk   (CLK_I),
        .rst_n (RST_I),
        .we    (w_wr_en),
        .re    (w_rd_en & w_hit),
        .addr  (w_index),
        .wdata (bus.DAT_I),
        .rdata (w_rdata)
    );

    assign bus.DAT_O = r_rd_miss ? '0 : w_rdata;

`ifdef WSHBN_SLAVE_RAM_ERR_EN
    assign bus.ACK_O = w_resp & w_hit;
    assign bus.ERR_O = w_resp & ~w_hit;
`else
    assign bus.ACK_O = w_resp;
`endif

endmodule

`default_nettype wire

// File: doc/wshbn_slave_ram.md
# wshbn_slave_ram

Wishbone classic single-port RAM responder: the memory-side end of the cache refill/writeback bus. Accepts word-addressed single-beat read and write cycles from the cache's Wishbone master and acknowledges each beat after a programmable number of wait states. A full cache block transfer is a sequence of such beats. The block holds the backing storage for the main-memory region of the memory map.

## Interface
Parameters:
- `MEM_DEPTH`, default `RAM_DEPTH` (package): number of words stored.
- `BASE_ADDR`, default `RAM_BASE_ADDR` (package): first word address decoded by this RAM.
- `WAIT_STATES`, default 2: idle cycles inserted between request sample and ACK; legal range 0..15.

Ports:
- `CLK_I`, in, 1: clock; all logic on its rising edge.
- `RST_I`, in, 1: reset, asynchronous, active-low.
- `ADR_I`, in, `ADDR_WIDTH`: word address.
- `DAT_I`, in, `WORD_WIDTH`: write data.
- `WE_I`, in, 1: 1 = write, 0 = read.
- `STB_I`, in, 1: strobe.
- `CYC_I`, in, 1: bus cycle valid.
- `DAT_O`, out, `WORD_WIDTH`: read data, valid only while `ACK_O`=1.
- `ACK_O`, out, 1: beat acknowledge, one cycle wide.
- `ERR_O`, out, 1: out-of-range error; present only with `WSHBN_SLAVE_RAM_ERR_EN`.

## Operation
- Request = `CYC_I & STB_I`.
- Address decode:
  - `hit = (ADR_I >= BASE_ADDR) && (ADR_I < BASE_ADDR+MEM_DEPTH)`.
  - `index = ADR_I - BASE_ADDR`, truncated to `$clog2(MEM_DEPTH)` bits.
- FSM states: IDLE, WAIT, RESP.
  - IDLE:
    - request and `WAIT_STATES`=0 -> RESP.
    - request and `WAIT_STATES`>0 -> WAIT, `wait_cnt` <= 1.
    - no request -> stay in IDLE.
  - WAIT:
    - request dropped -> IDLE. The beat is aborted: no write, no ACK.
    - `wait_cnt` == `WAIT_STATES` -> RESP.
    - otherwise `wait_cnt`++.
  - RESP:
    - `ACK_O`=1 for exactly this cycle; unconditional -> IDLE.
- Read: `DAT_O` is registered from `mem[index]` on the edge entering RESP, then held until the next RESP. A miss loads 0.
- Write: `mem[index] <= DAT_I` on the edge leaving RESP, only if `hit & WE_I & request`. A miss is silently dropped.
- `ADR_I`, `DAT_I` and `WE_I` are sampled during RESP. The master holds them stable from strobe until ACK.
- Memory contents are not cleared by reset. Initial contents are undefined.

## Timing
- Reset values: state IDLE, `wait_cnt` 0, `ACK_O` 0, `DAT_O` 0, `ERR_O` 0.
- Request first sampled high in IDLE at cycle 0 -> `ACK_O` high in cycle `WAIT_STATES+1`.
- Beat period with `STB_I` held high: `WAIT_STATES+2` cycles. IDLE always separates two ACKs, so `ACK_O` is never high in two consecutive cycles.
- A master that advances its address on the ACK edge presents the next word in the IDLE cycle. That word is accepted without a gap beyond the IDLE cycle.
- Request deasserted in the RESP cycle: `ACK_O` is still driven, and the write is suppressed.
- Reset asserted mid-beat: immediate return to IDLE with `ACK_O`=0. A write in progress is not committed.

## Configuration
- `WSHBN_SLAVE_RAM_ERR_EN` defined:
  - `ERR_O` port exists.
  - A miss in RESP drives `ERR_O`=1 and `ACK_O`=0 for that cycle.
- `WSHBN_SLAVE_RAM_ERR_EN` undefined:
  - No `ERR_O` port.
  - A miss acknowledges normally: reads return 0, writes are dropped.

## Structure
- `memory_mapping` package:
  - `RAM_BASE_ADDR`, `RAM_DEPTH`.
  - `wshbn_slave_st_t` enum {IDLE, WAIT, RESP}.
- `ADDR_WIDTH` and `WORD_WIDTH` come from the existing shared packages.
- Sub-module `wshbn_slave_ram_array`:
  - Synchronous single-port array: `we`, `addr`, `wdata`, registered `rdata`.
  - Keeps the storage inferable as block RAM, separate from the handshake FSM.

## Test plan
- Reset: `RST_I`=0 for 3 cycles -> `ACK_O`=0, `DAT_O`=0, FSM in IDLE.
- Single write then read, `WAIT_STATES`=2, `ADR_I`=`BASE_ADDR+5`:
  - Write `0xDEADBEEF` -> ACK in cycle 3.
  - Read of the same address -> ACK in cycle 3 with `DAT_O`=`0xDEADBEEF`.
- Block burst, `WAIT_STATES`=0: cache master writes 4 words `0x11..0x44` at `BASE_ADDR`, then reads them back -> 4 ACKs spaced 2 cycles apart, read data `0x11,0x22,0x33,0x44`, master `mem_res.ack` raised.
- Abort: `STB_I` dropped in the second WAIT cycle of a write to `BASE_ADDR+1` -> no ACK, memory word unchanged.
- Out of range, read of `BASE_ADDR+MEM_DEPTH`:
  - With `WSHBN_SLAVE_RAM_ERR_EN`: `ERR_O`=1 and `ACK_O`=0 in cycle `WAIT_STATES+1`.
  - Without it: `ACK_O`=1 with `DAT_O`=0.
- Reset mid-write: `RST_I` low during WAIT -> `ACK_O` low immediately. A subsequent read shows the old value.
